main_control_fsm: RTL and testbench
===================================

// Module: main_control_fsm
// PURPOSE
//  Multicycle RV32I main controller: walks each instruction through FETCH/DECODE/EXECUTE/MEM/WB.
//  Issues datapath selects, write enables and the 2-bit ALUOp consumed by ALUControl
//  (ALUControl turns ALUOp+funct3+funct7 into the 4-bit ALU operation).
//  Sits beside ALUControl in the part1 datapath. Stalls on a single-port memory ready handshake.
// PARAMETERS
//  OPW      7   opcode field width
//  STW      4   state register width (11 states used)
// PORTS
//  clk           in   1  rising-edge clock
//  reset         in   1  synchronous, active-high
//  opcode        in   7  instr[6:0] from the instruction register
//  zero          in   1  ALU zero flag (valid in the BEQ state)
//  mem_ready     in   1  memory has completed the current read/write this cycle
//  ALUOp         out  2  00 add, 01 sub (branch compare), 10 decode funct3/funct7
//  ALUSrcA       out  2  00 PC, 01 OldPC, 10 RD1
//  ALUSrcB       out  2  00 RD2, 01 ImmExt, 10 constant 4
//  ResultSrc     out  2  00 ALUOut, 01 Data, 10 ALUResult
//  ImmSrc        out  2  00 I-type, 01 S-type, 10 B-type, 11 J-type (from opcode, comb.)
//  AdrSrc        out  1  0 PC, 1 Result (memory address mux)
//  IRWrite       out  1  latch instruction/OldPC
//  PCWrite       out  1  PCUpdate | (Branch & zero)
//  RegWrite      out  1  register file write enable
//  MemWrite      out  1  data memory write enable
//  illegal_instr out  1  one-cycle pulse: unsupported opcode in DECODE
// BEHAVIOUR
//  Reset: state<=FETCH on the edge with reset=1; while reset=1, IRWrite, PCWrite, RegWrite, MemWrite,
//   illegal_instr all forced 0; selects = FETCH values (ALUOp 00, SrcA 00, SrcB 10, ResultSrc 10, AdrSrc 0).
//   Reset mid-instruction abandons it; no write enable asserts on the following edge.
//  Moore outputs decoded from state; only ImmSrc, PCWrite (zero) and mem_ready gating depend on inputs.
//  States/transitions:
//   FETCH    AdrSrc 0, SrcA 00, SrcB 10, ALUOp 00, ResultSrc 10. mem_ready=0: hold, IRWrite=PCWrite=0.
//            mem_ready=1: IRWrite=1, PCUpdate=1, -> DECODE.
//   DECODE   SrcA 01, SrcB 01, ALUOp 00 (OldPC+imm for branch target). By opcode:
//            0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1101111 -> JAL;
//            1100011 -> BEQ; any other -> FETCH with illegal_instr=1, no writes.
//   MEMADR   SrcA 10, SrcB 01, ALUOp 00; lw -> MEMREAD, sw -> MEMWRITE.
//   MEMREAD  AdrSrc 1, ResultSrc 00; wait for mem_ready, then -> MEMWB.
//   MEMWRITE AdrSrc 1, ResultSrc 00, MemWrite=mem_ready; mem_ready=1 -> FETCH, else hold.
//   MEMWB    ResultSrc 01, RegWrite 1 -> FETCH.
//   EXECR    SrcA 10, SrcB 00, ALUOp 10 -> ALUWB.   EXECI  SrcA 10, SrcB 01, ALUOp 10 -> ALUWB.
//   ALUWB    ResultSrc 00, RegWrite 1 -> FETCH.
//   JAL      SrcA 01, SrcB 10, ALUOp 00, ResultSrc 00, PCUpdate 1 -> ALUWB (rd<=OldPC+4).
//   BEQ      SrcA 10, SrcB 00, ALUOp 01, ResultSrc 00, Branch 1 -> FETCH; PCWrite = zero.
//  Latency (mem_ready tied 1): R/I 4 cycles, sw 4, beq 3, jal 4, lw 5. Each mem_ready=0 cycle adds 1.
//  Unused state encodings -> FETCH next cycle, all enables 0.
//  MemWrite and RegWrite never assert in the same cycle; at most one of IRWrite/MemWrite per cycle.
//  Opcode is sampled only in DECODE/MEMADR; IR is stable there (IRWrite low outside FETCH).
// STRUCTURE
//  Shared include rv_ctrl_defs.vh: opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL),
//   state encodings, ALUOp/ALUSrcA/ALUSrcB/ResultSrc/ImmSrc codes (ALUControl uses the same ALUOp codes).
//  One sub-module: imm_src_decoder (opcode -> ImmSrc, combinational; 00 for unknown opcodes).
//  main_control_fsm = state register + next-state logic + output decode + PCWrite gate.
// TESTING
//  1 reset=1 for 2 cycles mid-EXECR -> next cycle state FETCH, RegWrite=0, PCWrite=0, ALUOp=00.
//  2 opcode 0110011, mem_ready=1 -> FETCH,DECODE,EXECR(ALUOp=10,SrcB=00),ALUWB(RegWrite=1),FETCH.
//  3 opcode 0000011, mem_ready low 3 cycles in MEMREAD -> holds MEMREAD 3 cycles, MEMWB RegWrite=1,
//    ResultSrc=01; total 8 cycles.
//  4 opcode 1100011, zero=1 then repeat with zero=0 -> BEQ: ALUOp=01, PCWrite=1 / PCWrite=0; 3 cycles each.
//  5 opcode 0100011 -> MEMWRITE MemWrite=1 only with mem_ready=1, ImmSrc=01, RegWrite never 1.
//  6 opcode 1110011 (unsupported) -> illegal_instr=1 for exactly 1 cycle in DECODE, back to FETCH, no writes.

Source files
------------

// File: rtl/main_control_fsm_pkg.sv
// rtl/main_control_fsm_pkg.sv - shared RV32I control encodings
// Purpose: opcode constants, state encodings and datapath select codes shared by
//          main_control_fsm, imm_src_decoder and ALUControl (same ALUOp codes).
// Ports:   none (package).
package main_control_fsm_pkg;

    // Opcodes handled by the multicycle controller
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // State encodings; 11..15 are unused and recover to FETCH
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWRITE = 4'd4;
    localparam logic [3:0] S_MEMWB    = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic is_supported(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/main_control_fsm_imm_src_decoder.sv
// rtl/main_control_fsm_imm_src_decoder.sv - opcode to immediate-format select
// Purpose: combinational ImmSrc decode; unknown opcodes give I-type (00).
// Ports:   opcode_i  in  7  instr[6:0]
//          imm_src_o out 2  00 I, 01 S, 10 B, 11 J
module imm_src_decoder
    import main_control_fsm_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic [1:0] imm_src_o
);

    always_comb begin
        imm_src_o = IMM_I;
        case (opcode_i)
            OP_SW:   imm_src_o = IMM_S;
            OP_BEQ:  imm_src_o = IMM_B;
            OP_JAL:  imm_src_o = IMM_J;
            default: imm_src_o = IMM_I;
        endcase
    end

endmodule

// File: rtl/main_control_fsm.sv
// rtl/main_control_fsm.sv - multicycle RV32I main controller
// Purpose: walks each instruction through FETCH/DECODE/EXECUTE/MEM/WB, driving datapath
//          selects, write enables and ALUOp; stalls on mem_ready in FETCH/MEMREAD/MEMWRITE.
// Ports:   clk, reset (sync, active-high), opcode[6:0], zero, mem_ready  -> inputs
//          ALUOp, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc (2b each), AdrSrc, IRWrite,
//          PCWrite, RegWrite, MemWrite, illegal_instr                    -> outputs
module main_control_fsm
    import main_control_fsm_pkg::*;
#(
    parameter int OPW = 7,
    parameter int STW = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_ready,
    output logic [1:0]     ALUOp,
    output logic [1:0]     ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     ResultSrc,
    output logic [1:0]     ImmSrc,
    output logic           AdrSrc,
    output logic           IRWrite,
    output logic           PCWrite,
    output logic           RegWrite,
    output logic           MemWrite,
    output logic           illegal_instr
);

    logic [STW-1:0] state_q, state_d;
    logic           pc_update;
    logic           branch;

    imm_src_decoder u_imm_src_decoder (
        .opcode_i  (opcode),
        .imm_src_o (ImmSrc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_FETCH;
                endcase
            end
            // Only lw/sw reach MEMADR, so anything but lw is a store
            S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_MEMWB:    state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        // FETCH selects double as the idle/reset values
        ALUOp         = ALUOP_ADD;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_FOUR;
        ResultSrc     = RES_ALURESULT;
        AdrSrc        = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        MemWrite      = 1'b0;
        illegal_instr = 1'b0;
        pc_update     = 1'b0;
        branch        = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite   = mem_ready;
                pc_update = mem_ready;
            end
            S_DECODE: begin
                // Precompute the branch target OldPC+imm while decoding
                ALUSrcA       = SRCA_OLDPC;
                ALUSrcB       = SRCB_IMM;
                illegal_instr = !is_supported(opcode);
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                AdrSrc    = 1'b1;
                ResultSrc = RES_ALUOUT;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                ResultSrc = RES_ALUOUT;
                MemWrite  = mem_ready;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_RD2;
                ALUOp   = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
            end
            S_JAL: begin
                // ALU forms OldPC+4 for rd while PC takes the target held in ALUOut
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALUOUT;
                pc_update = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_RD2;
                ALUOp     = ALUOP_SUB;
                ResultSrc = RES_ALUOUT;
                branch    = 1'b1;
            end
            default: ;
        endcase

        PCWrite = pc_update | (branch & zero);

        if (reset) begin
            ALUOp         = ALUOP_ADD;
            ALUSrcA       = SRCA_PC;
            ALUSrcB       = SRCB_FOUR;
            ResultSrc     = RES_ALURESULT;
            AdrSrc        = 1'b0;
            IRWrite       = 1'b0;
            PCWrite       = 1'b0;
            RegWrite      = 1'b0;
            MemWrite      = 1'b0;
            illegal_instr = 1'b0;
        end
    end

endmodule

// File: tb/tb_main_control_fsm.sv
// tb/tb_main_control_fsm.sv - scoreboard bench for main_control_fsm
module tb_main_control_fsm;

    typedef enum int {
        T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWRITE, T_MEMWB,
        T_EXECR, T_EXECI, T_ALUWB, T_JAL, T_BEQ
    } st_t;

    typedef struct {
        string       name;
        logic [15:0] val;
        logic [15:0] mask;
    } exp_t;

    localparam logic [6:0] C_LW  = 7'b0000011;
    localparam logic [6:0] C_SW  = 7'b0100011;
    localparam logic [6:0] C_R   = 7'b0110011;
    localparam logic [6:0] C_I   = 7'b0010011;
    localparam logic [6:0] C_BEQ = 7'b1100011;
    localparam logic [6:0] C_JAL = 7'b1101111;
    localparam logic [6:0] C_BAD = 7'b1110011;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [1:0] ALUOp, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal_instr;

    int   checks = 0;
    int   errors = 0;
    int   drain_cycles;
    exp_t sb_q[$];

    main_control_fsm dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .ALUOp         (ALUOp),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ResultSrc     (ResultSrc),
        .ImmSrc        (ImmSrc),
        .AdrSrc        (AdrSrc),
        .IRWrite       (IRWrite),
        .PCWrite       (PCWrite),
        .RegWrite      (RegWrite),
        .MemWrite      (MemWrite),
        .illegal_instr (illegal_instr)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input st_t st, input logic [6:0] op,
                                   input logic z, input logic mr, input logic rst);
        exp_t e;
        logic [1:0] aop, sa, sb, rs, imm;
        logic adr, irw, pcw, rw, mw, ill;
        logic c_op, c_a, c_b, c_r, c_adr;
        aop = 2'b00; sa = 2'b00; sb = 2'b00; rs = 2'b00; adr = 1'b0;
        irw = 1'b0; pcw = 1'b0; rw = 1'b0; mw = 1'b0; ill = 1'b0;
        c_op = 1'b0; c_a = 1'b0; c_b = 1'b0; c_r = 1'b0; c_adr = 1'b0;
        case (op)
            C_SW:    imm = 2'b01;
            C_BEQ:   imm = 2'b10;
            C_JAL:   imm = 2'b11;
            default: imm = 2'b00;
        endcase
        if (rst) begin
            aop = 2'b00; sa = 2'b00; sb = 2'b10; rs = 2'b10; adr = 1'b0;
            c_op = 1'b1; c_a = 1'b1; c_b = 1'b1; c_r = 1'b1; c_adr = 1'b1;
        end else begin
            case (st)
                T_FETCH: begin
                    aop = 2'b00; sa = 2'b00; sb = 2'b10; rs = 2'b10; adr = 1'b0;
                    c_op = 1'b1; c_a = 1'b1; c_b = 1'b1; c_r = 1'b1; c_adr = 1'b1;
                    irw = mr; pcw = mr;
                end
                T_DECODE: begin
                    sa = 2'b01; sb = 2'b01; aop = 2'b00;
                    c_a = 1'b1; c_b = 1'b1; c_op = 1'b1;
                    ill = !(op == C_LW || op == C_SW || op == C_R || op == C_I ||
                            op == C_BEQ || op == C_JAL);
                end
                T_MEMADR: begin
                    sa = 2'b10; sb = 2'b01; aop = 2'b00;
                    c_a = 1'b1; c_b = 1'b1; c_op = 1'b1;
                end
                T_MEMREAD: begin
                    adr = 1'b1; rs = 2'b00; c_adr = 1'b1; c_r = 1'b1;
                end
                T_MEMWRITE: begin
                    adr = 1'b1; rs = 2'b00; c_adr = 1'b1; c_r = 1'b1; mw = mr;
                end
                T_MEMWB: begin
                    rs = 2'b01; c_r = 1'b1; rw = 1'b1;
                end
                T_EXECR: begin
                    sa = 2'b10; sb = 2'b00; aop = 2'b10;
                    c_a = 1'b1; c_b = 1'b1; c_op = 1'b1;
                end
                T_EXECI: begin
                    sa = 2'b10; sb = 2'b01; aop = 2'b10;
                    c_a = 1'b1; c_b = 1'b1; c_op = 1'b1;
                end
                T_ALUWB: begin
                    rs = 2'b00; c_r = 1'b1; rw = 1'b1;
                end
                T_JAL: begin
                    sa = 2'b01; sb = 2'b10; aop = 2'b00; rs = 2'b00;
                    c_a = 1'b1; c_b = 1'b1; c_op = 1'b1; c_r = 1'b1; pcw = 1'b1;
                end
                T_BEQ: begin
                    sa = 2'b10; sb = 2'b00; aop = 2'b01; rs = 2'b00;
                    c_a = 1'b1; c_b = 1'b1; c_op = 1'b1; c_r = 1'b1; pcw = z;
                end
                default: ;
            endcase
        end
        e.name = "";
        e.val  = {aop, sa, sb, rs, imm, adr, irw, pcw, rw, mw, ill};
        e.mask = {{2{c_op}}, {2{c_a}}, {2{c_b}}, {2{c_r}}, 2'b11, c_adr, 5'b11111};
        return e;
    endfunction

    task automatic step(input string nm, input st_t st, input logic [6:0] op,
                        input logic z, input logic mr, input logic rst);
        exp_t e;
        reset     = rst;
        opcode    = op;
        zero      = z;
        mem_ready = mr;
        e = model(st, op, z, mr, rst);
        e.name = nm;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] act;
        if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
                   AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal_instr};
            checks++;
            if ((act & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s: got %b required %b (care mask %b)",
                         e.name, act, e.val, e.mask);
            end
        end
    end

    initial begin
        reset = 1'b1; opcode = C_R; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        step("reset_0", T_FETCH, C_R, 1'b1, 1'b1, 1'b1);
        step("reset_1", T_FETCH, C_R, 1'b1, 1'b0, 1'b1);

        checks++;
        if (IRWrite !== 1'b0 || PCWrite !== 1'b0 || RegWrite !== 1'b0 ||
            MemWrite !== 1'b0 || illegal_instr !== 1'b0 || ALUOp !== 2'b00 ||
            ALUSrcA !== 2'b00 || ALUSrcB !== 2'b10 || ResultSrc !== 2'b10 ||
            AdrSrc !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: IRW %b PCW %b RW %b MW %b ILL %b ALUOp %b SrcA %b SrcB %b Res %b Adr %b",
                     IRWrite, PCWrite, RegWrite, MemWrite, illegal_instr,
                     ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc);
        end

        step("r_fetch",  T_FETCH,  C_R, 1'b1, 1'b1, 1'b0);
        step("r_decode", T_DECODE, C_R, 1'b1, 1'b1, 1'b0);
        step("r_execr",  T_EXECR,  C_R, 1'b1, 1'b1, 1'b0);
        step("r_aluwb",  T_ALUWB,  C_R, 1'b1, 1'b1, 1'b0);

        step("i_fetch",  T_FETCH,  C_I, 1'b0, 1'b1, 1'b0);
        step("i_decode", T_DECODE, C_I, 1'b0, 1'b1, 1'b0);
        step("i_execi",  T_EXECI,  C_I, 1'b0, 1'b1, 1'b0);
        step("i_aluwb",  T_ALUWB,  C_I, 1'b0, 1'b1, 1'b0);

        step("lw_fetch",  T_FETCH,   C_LW, 1'b0, 1'b1, 1'b0);
        step("lw_decode", T_DECODE,  C_LW, 1'b0, 1'b1, 1'b0);
        step("lw_memadr", T_MEMADR,  C_LW, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            step("lw_memread_stall", T_MEMREAD, C_LW, 1'b0, 1'b0, 1'b0);
        step("lw_memread", T_MEMREAD, C_LW, 1'b0, 1'b1, 1'b0);
        step("lw_memwb",   T_MEMWB,   C_LW, 1'b0, 1'b1, 1'b0);

        step("sw_fetch_stall",    T_FETCH,    C_SW, 1'b0, 1'b0, 1'b0);
        step("sw_fetch",          T_FETCH,    C_SW, 1'b0, 1'b1, 1'b0);
        step("sw_decode",         T_DECODE,   C_SW, 1'b0, 1'b1, 1'b0);
        step("sw_memadr",         T_MEMADR,   C_SW, 1'b0, 1'b1, 1'b0);
        step("sw_memwrite_stall", T_MEMWRITE, C_SW, 1'b0, 1'b0, 1'b0);
        step("sw_memwrite",       T_MEMWRITE, C_SW, 1'b0, 1'b1, 1'b0);

        step("beq1_fetch",  T_FETCH,  C_BEQ, 1'b1, 1'b1, 1'b0);
        step("beq1_decode", T_DECODE, C_BEQ, 1'b1, 1'b1, 1'b0);
        step("beq1_taken",  T_BEQ,    C_BEQ, 1'b1, 1'b1, 1'b0);
        step("beq0_fetch",  T_FETCH,  C_BEQ, 1'b0, 1'b1, 1'b0);
        step("beq0_decode", T_DECODE, C_BEQ, 1'b0, 1'b1, 1'b0);
        step("beq0_not",    T_BEQ,    C_BEQ, 1'b0, 1'b1, 1'b0);

        step("jal_fetch",  T_FETCH,  C_JAL, 1'b0, 1'b1, 1'b0);
        step("jal_decode", T_DECODE, C_JAL, 1'b0, 1'b1, 1'b0);
        step("jal_jal",    T_JAL,    C_JAL, 1'b0, 1'b1, 1'b0);
        step("jal_aluwb",  T_ALUWB,  C_JAL, 1'b0, 1'b1, 1'b0);

        step("bad_fetch",  T_FETCH,  C_BAD, 1'b0, 1'b1, 1'b0);
        step("bad_decode", T_DECODE, C_BAD, 1'b0, 1'b1, 1'b0);
        step("bad_refetch_stall", T_FETCH, C_BAD, 1'b0, 1'b0, 1'b0);

        step("mid_fetch",   T_FETCH,  C_R, 1'b0, 1'b1, 1'b0);
        step("mid_decode",  T_DECODE, C_R, 1'b0, 1'b1, 1'b0);
        step("mid_rst_0",   T_EXECR,  C_R, 1'b1, 1'b1, 1'b1);
        step("mid_rst_1",   T_FETCH,  C_R, 1'b1, 1'b1, 1'b1);
        step("post_fetch",  T_FETCH,  C_R, 1'b1, 1'b1, 1'b0);
        step("post_decode", T_DECODE, C_R, 1'b0, 1'b1, 1'b0);
        step("post_execr",  T_EXECR,  C_R, 1'b0, 1'b1, 1'b0);
        step("post_aluwb",  T_ALUWB,  C_R, 1'b0, 1'b1, 1'b0);
        step("end_fetch",   T_FETCH,  C_R, 1'b0, 1'b0, 1'b0);

        drain_cycles = 0;
        while (sb_q.size() > 0 && drain_cycles < 10) begin
            @(posedge clk);
            #1;
            drain_cycles++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d expected words never compared", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
